iir_mem_host: RTL and testbench
===============================

IIR_MEM_HOST -- requirements
Module: iir_mem_host

Interface
REQ-001 Parameter DEPTH, default 256, sample/result buffer depth in words (power of two).
REQ-002 Parameter AW, default 8, buffer index width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  rising-edge clock shared with the filter.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_valid/s_ready/s_data/s_last  in/out/in/in  1/1/16/1  sample upload stream, two's complement.
REQ-006 flt_rst  output  1  reset to filter; high holds filter at address 0.
REQ-007 load  input  1  filter read request.
REQ-008 RAddr  input  20  filter read address.
REQ-009 DIn  output  16  sample returned for RAddr.
REQ-010 WEN/WAddr/Yn  input  1/20/16  filter result write strobe, address, data.
REQ-011 data_done  output  1  tells filter all samples were consumed.
REQ-012 Finish  input  1  filter acknowledge of data_done.
REQ-013 m_valid/m_ready/m_data/m_last  out/in/out/out  1/1/16/1  result download stream.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 err  output  1  sticky watchdog error (REQ-030).

Function
REQ-016 FSM states IDLE, FILL, RUN, WAIT_FIN, DRAIN; one transition per clk max.
REQ-017 IDLE: s_ready=1; first s_valid beat stored at index 0, count=1, go FILL (or RUN if s_last).
REQ-018 FILL: s_ready=1; each s_valid beat written to sample buffer at count, count+1.
REQ-019 FILL exits to RUN on accepted beat with s_last=1, or when count reaches DEPTH (s_last ignored, s_ready drops same edge).
REQ-020 flt_rst=1 in IDLE, FILL, WAIT_FIN, DRAIN; flt_rst=0 only in RUN.
REQ-021 DIn combinational: sample[RAddr[AW-1:0]] when load=1 and RAddr<count, else 16'h0000.
REQ-022 On clk edge with WEN=1 and WAddr<count in RUN/WAIT_FIN: result[WAddr]<=Yn; other writes dropped.
REQ-023 data_done combinational: 1 in RUN when RAddr>=count, 1 throughout WAIT_FIN, else 0.
REQ-024 RUN -> WAIT_FIN on edge where data_done=1 (last write at WAddr=count-1 captured that edge).
REQ-025 WAIT_FIN -> DRAIN on edge where Finish=1; rd_ptr<=0.
REQ-026 DRAIN: m_valid=1, m_data=result[rd_ptr], m_last=(rd_ptr==count-1); beat transfers when m_ready=1.
REQ-027 Transfer with m_last=1 -> IDLE, count<=0; m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 s_ready=0 outside IDLE/FILL; s_valid then ignored, no data loss required.
REQ-029 count width AW+1; count=DEPTH legal; result entries never written read as last stored value (0 after reset).

Reset
REQ-030 rst=1 at any time (incl. mid-RUN/DRAIN) SHALL force IDLE immediately: count=0, rd_ptr=0, err=0.
REQ-031 Output reset values: flt_rst=1, data_done=0, DIn=0, s_ready=1, m_valid=0, m_last=0, m_data=0, busy=0, err=0.
REQ-032 Buffer contents SHALL be cleared to zero on reset.

Configuration
REQ-033 Macro IIR_MEM_HOST_WDOG_EN defined: counter starts on entry to RUN; if count+16 cycles pass without reaching DRAIN, err<=1 (sticky until rst) and FSM goes to DRAIN.
REQ-034 Macro undefined: no watchdog logic, err tied 0, RUN/WAIT_FIN wait indefinitely.

Verification
REQ-035 Upload 4 samples {0x0100,0x0200,0xFF00,0x0000}, s_last on 4th -> RUN, flt_rst=0, DIn=0x0100 at RAddr=0, data_done=1 at RAddr=4.
REQ-036 Model filter writes Yn=0xA000+WAddr for WAddr 0..3, Finish one cycle after data_done -> DRAIN outputs 0xA000..0xA003, m_last on 4th, then IDLE.
REQ-037 Upload DEPTH=256 samples without s_last -> s_ready=0 after 256th beat, RUN entered, count=256.
REQ-038 DRAIN with m_ready toggled 1,0,0,1 -> m_data constant during stalls, no beat skipped or duplicated.
REQ-039 Assert rst mid-DRAIN after 2 beats -> next cycle IDLE, m_valid=0, flt_rst=1; fresh 1-sample upload completes normally.
REQ-040 With IIR_MEM_HOST_WDOG_EN, 4 samples, Finish held 0 -> err=1 exactly 20 cycles after RUN entry, DRAIN begins; without macro err stays 0.

Source files
------------

// File: rtl/iir_mem_host.sv
// Sample/result buffer host for an IIR filter core: uploads samples, serves filter reads, collects results, streams them out.
// Optional RUN/WAIT_FIN watchdog is compiled in when IIR_MEM_HOST_WDOG_EN is defined.
module iir_mem_host #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        flt_rst,
  input  logic        load,
  input  logic [19:0] RAddr,
  output logic [15:0] DIn,
  input  logic        WEN,
  input  logic [19:0] WAddr,
  input  logic [15:0] Yn,
  output logic        data_done,
  input  logic        Finish,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    RUN      = 3'd2,
    WAIT_FIN = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

  state_t      state_r;
  logic [AW:0] count_r;
  logic [AW:0] rd_ptr_r;
  logic [15:0] sample_mem [DEPTH];
  logic [15:0] result_mem [DEPTH];

  logic        s_accept_s;
  logic        raddr_lt_count_s;
  logic        waddr_lt_count_s;
  logic        res_we_s;
  logic        wdog_fire_s;

  // Stream handshakes, filter-side decode and download outputs, all derived from registered state.
  always_comb begin
    s_ready          = (state_r == IDLE) || (state_r == FILL);
    s_accept_s       = s_valid && s_ready;
    busy             = (state_r != IDLE);
    flt_rst          = (state_r != RUN);
    raddr_lt_count_s = (RAddr < {{(19 - AW){1'b0}}, count_r});
    waddr_lt_count_s = (WAddr < {{(19 - AW){1'b0}}, count_r});
    res_we_s         = WEN && waddr_lt_count_s && ((state_r == RUN) || (state_r == WAIT_FIN));
    data_done        = ((state_r == RUN) && !raddr_lt_count_s) || (state_r == WAIT_FIN);
    if (load && raddr_lt_count_s) begin
      DIn = sample_mem[RAddr[AW-1:0]];
    end else begin
      DIn = 16'h0000;
    end
    if (state_r == DRAIN) begin
      m_valid = 1'b1;
      m_data  = result_mem[rd_ptr_r[AW-1:0]];
      m_last  = (rd_ptr_r == (count_r - ONE_W));
    end else begin
      m_valid = 1'b0;
      m_data  = 16'h0000;
      m_last  = 1'b0;
    end
  end

`ifdef IIR_MEM_HOST_WDOG_EN
  logic [AW+1:0] wdog_r;
  logic          err_r;

  // Watchdog: cycles spent in RUN/WAIT_FIN; fires once count+16 edges have elapsed since RUN entry.
  always_comb begin
    wdog_fire_s = ((state_r == RUN) || (state_r == WAIT_FIN)) &&
                  (wdog_r == ({1'b0, count_r} + (AW + 2)'(15)));
    err         = err_r;
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_r <= '0;
      err_r  <= 1'b0;
    end else if ((state_r == RUN) || (state_r == WAIT_FIN)) begin
      wdog_r <= wdog_r + (AW + 2)'(1);
      if (wdog_fire_s) begin
        err_r <= 1'b1;
      end
    end else begin
      wdog_r <= '0;
    end
  end
`else
  // No watchdog: the filter may take as long as it likes.
  always_comb begin
    wdog_fire_s = 1'b0;
    err         = 1'b0;
  end
`endif

  // Control FSM: sample count, drain pointer, state sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= '0;
      rd_ptr_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (s_valid) begin
            count_r <= ONE_W;
            state_r <= (s_last || (DEPTH_W == ONE_W)) ? RUN : FILL;
          end
        end
        FILL: begin
          if (s_valid) begin
            count_r <= count_r + ONE_W;
            // A full buffer starts the run even without s_last.
            if (s_last || ((count_r + ONE_W) == DEPTH_W)) begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (wdog_fire_s) begin
            state_r  <= DRAIN;
            rd_ptr_r <= '0;
          end else if (data_done) begin
            state_r <= WAIT_FIN;
          end
        end
        WAIT_FIN: begin
          if (wdog_fire_s || Finish) begin
            state_r  <= DRAIN;
            rd_ptr_r <= '0;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (m_last) begin
              state_r  <= IDLE;
              count_r  <= '0;
              rd_ptr_r <= '0;
            end else begin
              rd_ptr_r <= rd_ptr_r + ONE_W;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          count_r  <= '0;
          rd_ptr_r <= '0;
        end
      endcase
    end
  end

  // Sample buffer: cleared on reset, written at the running count while uploading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sample_mem[i] <= 16'h0000;
      end
    end else if (s_accept_s) begin
      sample_mem[count_r[AW-1:0]] <= s_data;
    end
  end

  // Result buffer: cleared on reset, written by the filter for in-range addresses only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_mem[i] <= 16'h0000;
      end
    end else if (res_we_s) begin
      result_mem[WAddr[AW-1:0]] <= Yn;
    end
  end

endmodule

// File: tb/tb_iir_mem_host.sv
// Self-checking bench for iir_mem_host: vector table for filter-side reads, scoreboard queue for the result stream.
module tb_iir_mem_host;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_last = 1'b0, load = 1'b0, WEN = 1'b0, Finish = 1'b0, m_ready = 1'b0;
  logic [15:0] s_data = 16'h0000, Yn = 16'h0000;
  logic [19:0] RAddr = 20'h0, WAddr = 20'h0;
  logic        s_ready, flt_rst, data_done, m_valid, m_last, busy, err;
  logic [15:0] DIn, m_data;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] res_model [DEPTH];

  typedef struct {
    logic        load;
    logic [19:0] raddr;
    logic [15:0] din;
    logic        done;
  } vec_t;
  vec_t vecs[8];

  iir_mem_host #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .flt_rst(flt_rst), .load(load), .RAddr(RAddr), .DIn(DIn),
    .WEN(WEN), .WAddr(WAddr), .Yn(Yn),
    .data_done(data_done), .Finish(Finish),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; load = 1'b0; WEN = 1'b0; Finish = 1'b0; m_ready = 1'b0;
    RAddr = 20'h0; WAddr = 20'h0;
    for (int i = 0; i < DEPTH; i++) res_model[i] = 16'h0000;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic upload(input logic [15:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic filter_write(input int w, input logic [19:0] raddr, input logic [15:0] y, input int cnt);
    WEN = 1'b1; WAddr = 20'(w); Yn = y; load = 1'b1; RAddr = raddr;
    if (w < cnt) res_model[w] = y;
    tick();
    WEN = 1'b0; load = 1'b0; RAddr = 20'h0;
  endtask

  task automatic start_drain(input int n);
    Finish = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(res_model[i]);
    tick();
    Finish = 1'b0;
  endtask

  // Drain with a repeating 4-cycle m_ready pattern (bit 0 first), checking order, m_last and stall stability.
  task automatic drain(input logic [3:0] pat, input int budget);
    logic        done = 1'b0;
    logic        stalled = 1'b0;
    logic [15:0] held = 16'h0000;
    logic [15:0] want;
    for (int c = 0; c < budget && !done; c++) begin
      m_ready = pat[c % 4];
      #1;
      if (m_valid !== 1'b1) begin
        chk("drain_valid", {31'h0, m_valid}, 32'h1);
        done = 1'b1;
      end else begin
        if (stalled) chk("stall_hold", {16'h0, m_data}, {16'h0, held});
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 32'h1, 32'h0);
            done = 1'b1;
          end else begin
            want = exp_q.pop_front();
            chk("m_data", {16'h0, m_data}, {16'h0, want});
            chk("m_last", {31'h0, m_last}, {31'h0, (exp_q.size() == 0)});
            if (m_last) done = 1'b1;
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = m_data;
        end
        @(posedge clk);
        #1;
      end
    end
    m_ready = 1'b0;
    if (!done) chk("drain_timeout", 32'h1, 32'h0);
    chk("drain_queue_empty", exp_q.size(), 32'h0);
    chk("idle_after_drain", {30'h0, busy, s_ready}, 32'h1);
  endtask

  function automatic logic [15:0] samp(input int i);
    return 16'(i * 3 + 1);
  endfunction

  task automatic upload4();
    upload(16'h0100, 1'b0);
    upload(16'h0200, 1'b0);
    upload(16'hFF00, 1'b0);
    upload(16'h0000, 1'b1);
  endtask

  task automatic write4();
    for (int w = 0; w < 4; w++)
      filter_write(w, (w == 3) ? 20'd4 : 20'(w), 16'hA000 + 16'(w), 4);
  endtask

  initial begin
    vecs[0] = '{1'b1, 20'd0,      16'h0100, 1'b0};
    vecs[1] = '{1'b1, 20'd1,      16'h0200, 1'b0};
    vecs[2] = '{1'b1, 20'd2,      16'hFF00, 1'b0};
    vecs[3] = '{1'b1, 20'd3,      16'h0000, 1'b0};
    vecs[4] = '{1'b0, 20'd1,      16'h0000, 1'b0};
    vecs[5] = '{1'b1, 20'd4,      16'h0000, 1'b1};
    vecs[6] = '{1'b1, 20'hFFFFF,  16'h0000, 1'b1};
    vecs[7] = '{1'b0, 20'd4,      16'h0000, 1'b1};

    // Reset values while rst is held.
    #3;
    chk("rst_outs", {23'h0, flt_rst, data_done, s_ready, m_valid, m_last, busy, err, 2'b00},
        {23'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    chk("rst_din_mdata", {DIn, m_data}, 32'h0);
    do_reset();

    // Basic 4-sample run: reads from the table, filter writes, drain.
    upload4();
    chk("run_flt_rst", {31'h0, flt_rst}, 32'h0);
    chk("run_s_ready", {31'h0, s_ready}, 32'h0);
    chk("run_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      load = vecs[i].load; RAddr = vecs[i].raddr;
      #1;
      chk($sformatf("vec%0d_din", i), {16'h0, DIn}, {16'h0, vecs[i].din});
      chk($sformatf("vec%0d_done", i), {31'h0, data_done}, {31'h0, vecs[i].done});
    end
    load = 1'b0; RAddr = 20'h0;
    write4();
    chk("waitfin_done", {30'h0, data_done, flt_rst}, 32'h3);
    start_drain(4);
    drain(4'b1111, 20);

    // Full buffer without s_last, stray upload in RUN, stalled drain, dropped out-of-range write.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("fill_ready_last", {31'h0, s_ready}, 32'h1);
      upload(samp(i), 1'b0);
    end
    chk("full_s_ready", {31'h0, s_ready}, 32'h0);
    chk("full_flt_rst", {31'h0, flt_rst}, 32'h0);
    upload(16'hFFFF, 1'b0);
    load = 1'b1; RAddr = 20'd0; #1;
    chk("full_din0", {16'h0, DIn}, {16'h0, samp(0)});
    RAddr = 20'd255; #1;
    chk("full_din255", {16'h0, DIn}, {16'h0, samp(255)});
    chk("full_done255", {31'h0, data_done}, 32'h0);
    RAddr = 20'd256; #1;
    chk("full_done256", {31'h0, data_done}, 32'h1);
    chk("full_din256", {16'h0, DIn}, 32'h0);
    load = 1'b0; RAddr = 20'd0;
    for (int w = 0; w < DEPTH; w++)
      filter_write(w, (w == DEPTH - 1) ? 20'd256 : 20'(w), 16'(w) ^ 16'h5A5A, DEPTH);
    filter_write(256, 20'd0, 16'hDEAD, DEPTH);
    start_drain(DEPTH);
    drain(4'b1001, 2000);

    // Reset mid-drain after two beats, then a one-sample run on cleared buffers.
    upload4();
    write4();
    start_drain(4);
    for (int b = 0; b < 2; b++) begin
      m_ready = 1'b1; #1;
      chk("pre_rst_data", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
      tick();
    end
    m_ready = 1'b0;
    rst = 1'b1; #1;
    chk("midrst_outs", {28'h0, m_valid, flt_rst, busy, s_ready}, 32'h5);
    do_reset();
    upload(16'h1234, 1'b1);
    chk("one_run", {31'h0, flt_rst}, 32'h0);
    load = 1'b1; RAddr = 20'd0; #1;
    chk("one_din", {16'h0, DIn}, 32'h1234);
    RAddr = 20'd1;
    tick();
    load = 1'b0; RAddr = 20'd0;
    chk("one_waitfin", {31'h0, data_done}, 32'h1);
    start_drain(1);
    drain(4'b1111, 10);

    // Filter never finishes.
    upload4();
`ifdef IIR_MEM_HOST_WDOG_EN
    for (int k = 1; k < 20; k++) tick();
    chk("wdog_before", {31'h0, err}, 32'h0);
    tick();
    chk("wdog_err", {31'h0, err}, 32'h1);
    chk("wdog_drain", {31'h0, m_valid}, 32'h1);
`else
    for (int k = 0; k < 40; k++) tick();
    chk("nowdog_err", {31'h0, err}, 32'h0);
    chk("nowdog_stuck", {30'h0, busy, flt_rst}, 32'h2);
`endif
    do_reset();
    chk("final_err", {31'h0, err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
